// File: rtl/mux_sel_pkg.sv
// Shared constants, state type and helpers for the round-robin mux select generator.
package mux_sel_pkg;

  localparam int unsigned N_CH    = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned ABORT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [N_CH-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    return N_CH'(1) << s;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating priority finder: first requester at or after start, wrapping.
module rr_pick4
  import mux_sel_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    idx   = start;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      cand = start + SEL_W'(i);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_sel_gen_4.sv
// Round-robin select generator driving a 4:1 mux select, held stable until out_ready.
// Define RR_SEL_LOCK_EN to let the owner keep the grant across transfers with lock.
module rr_sel_gen_4
  import mux_sel_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH-1:0]    req,
  input  logic               out_ready,
  input  logic               lock,
  output logic [SEL_W-1:0]   sel,
  output logic [N_CH-1:0]    gnt,
  output logic               valid,
  output logic [ABORT_W-1:0] abort_cnt
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [N_CH-1:0]    gnt_q, gnt_d;
  logic               valid_q, valid_d;
  logic [ABORT_W-1:0] abort_q, abort_d;

  logic [N_CH-1:0]    pick_req_c;
  logic [SEL_W-1:0]   pick_start_c;
  logic [SEL_W-1:0]   pick_idx_c;
  logic               pick_found_c;
  logic               lock_hold_c;

`ifdef RR_SEL_LOCK_EN
  assign lock_hold_c = lock & req[sel_q];
`else
  logic unused_lock;
  assign unused_lock = lock;
  assign lock_hold_c = 1'b0;
`endif

  // In GRANT the owner is masked so it is only re-granted when nobody else asks.
  assign pick_req_c   = (state_q == GRANT) ? (req & ~sel_onehot(sel_q)) : req;
  assign pick_start_c = (state_q == GRANT) ? (sel_q + SEL_W'(1)) : ptr_q;

  rr_pick4 u_pick (
    .req   (pick_req_c),
    .start (pick_start_c),
    .idx   (pick_idx_c),
    .found (pick_found_c)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    abort_d = abort_q;
    if (state_q == IDLE) begin
      if (pick_found_c) begin
        sel_d   = pick_idx_c;
        state_d = GRANT;
      end
    end else begin
      if (out_ready) begin
        if (!lock_hold_c) begin
          ptr_d = sel_q + SEL_W'(1);
          if (pick_found_c) begin
            sel_d = pick_idx_c;
          end else if (!req[sel_q]) begin
            state_d = IDLE;
          end
        end
      end else if (!req[sel_q]) begin
        state_d = IDLE;
        if (abort_q != '1) begin
          abort_d = abort_q + ABORT_W'(1);
        end
      end
    end
    valid_d = (state_d == GRANT);
    gnt_d   = valid_d ? sel_onehot(sel_d) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      abort_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      abort_q <= abort_d;
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign valid     = valid_q;
  assign abort_cnt = abort_q;

endmodule

// File: tb/tb_rr_sel_gen_4.sv
// Self-checking bench for rr_sel_gen_4: vector table through a scoreboard queue,
// plus an asynchronous reset taken in the middle of a grant.
module tb_rr_sel_gen_4;

  typedef struct {
    int         id;
    logic [3:0] req;
    logic       ordy;
    logic       lck;
    logic       valid;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic [7:0] abort;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic       out_ready = 1'b0;
  logic       lock = 1'b0;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       valid;
  logic [7:0] abort_cnt;

  int errors = 0;
  int checks = 0;

  vec_t vecs[$];
  vec_t exp_q[$];

  rr_sel_gen_4 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .lock      (lock),
    .sel       (sel),
    .gnt       (gnt),
    .valid     (valid),
    .abort_cnt (abort_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic o, input logic l,
                     input logic v, input logic [1:0] s, input logic [3:0] g, input logic [7:0] a);
    vec_t t;
    t.id = vecs.size(); t.req = r; t.ordy = o; t.lck = l;
    t.valid = v; t.sel = s; t.gnt = g; t.abort = a;
    vecs.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t e;
    // full rotation
    for (int i = 0; i < 2; i++) begin
      add(4'b1111, 1, 0, 1, 2'd0, 4'b0001, 8'd0);
      add(4'b1111, 1, 0, 1, 2'd1, 4'b0010, 8'd0);
      add(4'b1111, 1, 0, 1, 2'd2, 4'b0100, 8'd0);
      add(4'b1111, 1, 0, 1, 2'd3, 4'b1000, 8'd0);
    end
    add(4'b0000, 1, 0, 0, 2'd3, 4'b0000, 8'd0);
    // backpressure
    for (int i = 0; i < 5; i++) add(4'b0011, 0, 0, 1, 2'd0, 4'b0001, 8'd0);
    add(4'b0011, 1, 0, 1, 2'd1, 4'b0010, 8'd0);
    // walk owner to 3 with ptr=3, then abandon
    add(4'b0100, 1, 0, 1, 2'd2, 4'b0100, 8'd0);
    add(4'b1000, 1, 0, 1, 2'd3, 4'b1000, 8'd0);
    add(4'b1000, 0, 0, 1, 2'd3, 4'b1000, 8'd0);
    add(4'b0000, 0, 0, 0, 2'd3, 4'b0000, 8'd1);
    add(4'b1001, 0, 0, 1, 2'd3, 4'b1000, 8'd1);
    add(4'b1001, 1, 0, 1, 2'd0, 4'b0001, 8'd1);
    // sole requester, then drop with out_ready counted as transfer
    add(4'b0010, 1, 0, 1, 2'd1, 4'b0010, 8'd1);
    add(4'b0010, 1, 0, 1, 2'd1, 4'b0010, 8'd1);
    add(4'b0010, 1, 0, 1, 2'd1, 4'b0010, 8'd1);
    add(4'b0000, 1, 0, 0, 2'd1, 4'b0000, 8'd1);
    // bring ptr to 0 via owner 3
    add(4'b1000, 0, 0, 1, 2'd3, 4'b1000, 8'd1);
    add(4'b1000, 1, 0, 1, 2'd3, 4'b1000, 8'd1);
    // lock burst
    add(4'b0101, 1, 1, 1, 2'd0, 4'b0001, 8'd1);
`ifdef RR_SEL_LOCK_EN
    add(4'b0101, 1, 1, 1, 2'd0, 4'b0001, 8'd1);
    add(4'b0101, 1, 1, 1, 2'd0, 4'b0001, 8'd1);
`else
    add(4'b0101, 1, 1, 1, 2'd2, 4'b0100, 8'd1);
    add(4'b0101, 1, 1, 1, 2'd0, 4'b0001, 8'd1);
`endif
    add(4'b0101, 1, 0, 1, 2'd2, 4'b0100, 8'd1);

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 0, 32'(valid), 32'd0);
    chk("rst_sel",   0, 32'(sel),   32'd0);
    chk("rst_gnt",   0, 32'(gnt),   32'd0);
    chk("rst_abort", 0, 32'(abort_cnt), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      req = vecs[i].req; out_ready = vecs[i].ordy; lock = vecs[i].lck;
      exp_q.push_back(vecs[i]);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL scoreboard[%0d]: got empty queue expected entry", i);
      end else begin
        e = exp_q.pop_front();
        chk("valid", e.id, 32'(valid), 32'(e.valid));
        chk("sel",   e.id, 32'(sel),   32'(e.sel));
        chk("gnt",   e.id, 32'(gnt),   32'(e.gnt));
        chk("abort", e.id, 32'(abort_cnt), 32'(e.abort));
      end
    end

    // asynchronous reset while owner 2 is held under backpressure
    req = 4'b0100; out_ready = 1'b0; lock = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 0, 32'(valid), 32'd1);
    chk("pre_rst_sel",   0, 32'(sel),   32'd2);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", 0, 32'(valid), 32'd0);
    chk("async_sel",   0, 32'(sel),   32'd0);
    chk("async_gnt",   0, 32'(gnt),   32'd0);
    chk("async_abort", 0, 32'(abort_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 0, 32'(valid), 32'd1);
    chk("post_rst_sel",   0, 32'(sel),   32'd2);
    chk("post_rst_gnt",   0, 32'(gnt),   32'b0100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_sel_gen_4.md
# rr_sel_gen_4

Round-robin select generator that sits directly upstream of the 4:1 multiplexer (`mux_4x1`) and drives its 2-bit select. Four requesters raise `req`. The block grants one requester at a time, presents the owner's index on `sel` together with `valid`, and holds that select stable until the downstream consumer accepts with `out_ready`. Fairness rotates past each served channel, and back-to-back grants sustain one transfer per cycle.

## Interface
Parameters:
- `N_CH`, 4, number of requesters. Fixed at 4; it matches the mux width.
- `SEL_W`, 2, width of `sel`; equals log2(`N_CH`).

Ports (one clock; reset is asynchronous and active-high):
- `clk`, input, 1, rising-edge clock.
- `rst`, input, 1, asynchronous active-high reset.
- `req`, input, 4, per-channel request. Bit k high means channel k wants the mux path.
- `out_ready`, input, 1, downstream accepts the currently selected data this cycle.
- `lock`, input, 1, owner asks to keep the grant after a transfer. Only honoured when `RR_SEL_LOCK_EN` is defined.
- `sel`, output, 2, registered mux select, equal to the owner index.
- `gnt`, output, 4, registered one-hot grant, equal to 1<<`sel` when `valid`, else 0.
- `valid`, output, 1, registered; the select is meaningful this cycle.
- `abort_cnt`, output, 8, saturating count of grants abandoned because the owner dropped `req`.

## Operation
- State `ptr` (2 bits) holds the highest-priority channel for the next arbitration.
- Pick function: the first k in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with `req[k]`=1. `found`=|req.
- FSM with two states:
  - IDLE: `valid`=0, `gnt`=0, `sel` holds its last value.
    - If `found`: owner<=pick(ptr, req), go to GRANT.
    - Else stay in IDLE.
  - GRANT: `valid`=1, `sel`=owner. Each cycle, the first matching rule below applies:
    - Transfer (`out_ready`=1): ptr<=owner+1 mod 4.
      - If lock is enabled and honoured (see Configuration), the owner is kept and the block stays in GRANT.
      - Otherwise it re-arbitrates in the same cycle using `req` with the owner bit masked, from ptr=owner+1. The owner's own bit is considered last, so a sole requester is re-granted.
      - If nothing is found it goes to IDLE.
    - Abandon (`req[owner]`=0 and `out_ready`=0): go to IDLE; ptr is unchanged; `abort_cnt`+=1, saturating at 255.
    - Otherwise hold owner and `sel` unchanged.
- Transfer takes priority over abandon when both occur in the same cycle.
- Wrap-around: ptr goes 3 -> 0.

## Timing
- Reset values: state=IDLE, ptr=0, `sel`=0, `gnt`=0, `valid`=0, `abort_cnt`=0. Reset may arrive mid-grant; outputs clear immediately without waiting for a clock edge.
- Latency from `req` rising in IDLE to `valid`: 1 cycle, because outputs are registered.
- Back-to-back: with continuous requests and `out_ready`=1, a new owner appears every cycle and `valid` stays high.
- `sel` never changes while `valid`=1 and `out_ready`=0, except by abandon, which first drops `valid`.
- Inputs are sampled on the rising `clk` edge. The `sel`-to-mux path is combinational in the consumer.

## Configuration
- `RR_SEL_LOCK_EN` defined: on a transfer with `lock`=1 and `req[owner]`=1, the owner keeps the grant, stays in GRANT, and ptr is not advanced. This supports burst transfers.
- `RR_SEL_LOCK_EN` undefined: the `lock` port is present but ignored, and every transfer rotates.

## Structure
- Package `mux_sel_pkg` holds:
  - constants `N_CH`=4 and `SEL_W`=2;
  - the state typedef (IDLE, GRANT);
  - the `abort_cnt` width constant (8).
- Sub-module `rr_pick4` is a combinational rotating priority finder.
  - Inputs: `req[3:0]`, `start[1:0]`.
  - Outputs: `idx[1:0]`, `found`.
  - Instantiated once. The masked re-arbitration reuses it by feeding `req` with the owner bit cleared, falling back to the owner bit.

## Test plan
- Reset mid-grant: `req`=0100, hold `out_ready`=0, pulse `rst` asynchronously -> `valid`/`gnt`/`sel` go to 0 immediately; after release with `req`=0100, `valid`=1 and `sel`=2 one cycle later.
- Full rotation: `req`=1111, `out_ready`=1 for 8 cycles -> `sel` sequence 0,1,2,3,0,1,2,3 with `valid` continuously 1.
- Backpressure: `req`=0011, `out_ready`=0 for 5 cycles -> `sel`=0 and `gnt`=0001 stable; `out_ready`=1 -> next cycle `sel`=1.
- Abandon: owner `sel`=3, drop `req[3]` with `out_ready`=0 -> next cycle `valid`=0 and `abort_cnt` goes 0 -> 1; ptr still 3, so `req`=1001 grants `sel`=3 first.
- Sole requester plus simultaneous event: `req`=0010, `out_ready`=1 every cycle -> `sel`=1 every cycle; drop `req[1]` in the same cycle as `out_ready`=1 -> counted as a transfer, `abort_cnt` unchanged, then IDLE.
- Lock (macro defined): `req`=0101, `lock`=1, `out_ready`=1 for 3 cycles -> `sel`=0 on all three; `lock`=0 -> next `sel`=2. With the macro undefined, the same stimulus gives `sel` 0,2,0,2.
